// File: rtl/bus_pkg.sv
// Shared types and the default ROM/RAM/UART/SR memory map for the bus decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEF_N_SLAVES = 4;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_WS_W     = 4;

    // Slice i belongs to slave i: ROM, RAM, UART, status register.
    localparam logic [DEF_N_SLAVES*DEF_ADDR_W-1:0] DEF_BASE =
        {32'h0000_0504, 32'h0000_0500, 32'h0000_0400, 32'h0000_0000};
    localparam logic [DEF_N_SLAVES*DEF_ADDR_W-1:0] DEF_MASK =
        {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF00, 32'hFFFF_FC00};
    localparam logic [DEF_N_SLAVES*DEF_WS_W-1:0] DEF_WAIT =
        {4'd0, 4'd2, 4'd0, 4'd0};

endpackage

// File: rtl/bus_decoder_ws_region_match.sv
// Address-to-region decode: masked compare against every base, lowest index wins.
// Latency: combinational.
// Backpressure: none.
module region_match #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int IDX_W    = 2
) (
    input  logic [ADDR_W-1:0]          addr,
    input  logic [N_SLAVES*ADDR_W-1:0] base,
    input  logic [N_SLAVES*ADDR_W-1:0] mask,
    output logic                       hit,
    output logic [IDX_W-1:0]           idx
);

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & mask[i*ADDR_W +: ADDR_W]) == base[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_decoder_ws.sv
// Registered memory-map decoder with per-region wait states; DECODE_ERR_EN enables err on unmapped access.
// Latency: mapped access ready W+2 cycles after req is sampled, unmapped 1 cycle; all outputs registered.
// Backpressure: req is sampled only in IDLE and must be held stable until ready; one access in flight.
module bus_decoder_ws
    import bus_pkg::*;
#(
    parameter int N_SLAVES = DEF_N_SLAVES,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WS_W     = DEF_WS_W,
    parameter logic [N_SLAVES*ADDR_W-1:0] BASE = DEF_BASE,
    parameter logic [N_SLAVES*ADDR_W-1:0] MASK = DEF_MASK,
    parameter logic [N_SLAVES*WS_W-1:0]   WAIT = DEF_WAIT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       ready,
    output logic                       err,
    output logic [N_SLAVES-1:0]        cs,
    output logic                       s_we,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    state_t              state, state_nxt;
    logic [WS_W-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]    sel, sel_nxt, hit_idx;
    logic                hit;
    logic                we_l, we_nxt;
    logic                take;
    logic                unmapped_req;

    logic [N_SLAVES-1:0] cs_nxt;
    logic                s_we_nxt;
    logic [ADDR_W-1:0]   s_addr_nxt;
    logic [DATA_W-1:0]   s_wdata_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic                ready_nxt;

    region_match #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W)
    ) u_match (
        .addr (addr),
        .base (BASE),
        .mask (MASK),
        .hit  (hit),
        .idx  (hit_idx)
    );

    assign take         = (state == IDLE) && req;
    assign unmapped_req = take && !hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= '0;
            we_l  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            we_l  <= we_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        we_nxt    = take ? we : we_l;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        state_nxt = ACCESS;
                        sel_nxt   = hit_idx;
                        cnt_nxt   = WAIT[hit_idx*WS_W +: WS_W];
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - WS_W'(1);
                end else begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from where the FSM is heading.
    always_comb begin
        cs_nxt      = (state_nxt == ACCESS) ? (N_SLAVES'(1) << sel_nxt) : '0;
        s_we_nxt    = (state_nxt == ACCESS) && we_nxt;
        s_addr_nxt  = take ? addr  : s_addr;
        s_wdata_nxt = take ? wdata : s_wdata;
        ready_nxt   = (state_nxt == RESP);
        rdata_nxt   = rdata;
        if ((state == ACCESS) && (cnt == '0)) begin
            rdata_nxt = we_l ? '0 : s_rdata[sel*DATA_W +: DATA_W];
        end else if (unmapped_req) begin
            rdata_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs      <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
        end else begin
            cs      <= cs_nxt;
            s_we    <= s_we_nxt;
            s_addr  <= s_addr_nxt;
            s_wdata <= s_wdata_nxt;
            rdata   <= rdata_nxt;
            ready   <= ready_nxt;
        end
    end

`ifdef DECODE_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= unmapped_req;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_decoder_ws.sv
// Scoreboard bench for bus_decoder_ws: randomized accesses vs an address-range reference model.
module tb_bus_decoder_ws;

`ifdef DECODE_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif
    localparam int WS_REF [4] = '{0, 0, 2, 0};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         ready;
    logic         err;
    logic [3:0]   cs;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;
    logic [31:0]  sd [4];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        we;
        logic        err;
        logic [3:0]  cs;
        int          cs_cycles;
        int          cs_start;
        int          rdy_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_ok = 0;
    int   cs_cnt = 0;
    bit   abort = 1'b0;

    assign s_rdata = {sd[3], sd[2], sd[1], sd[0]};

    bus_decoder_ws dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err),
        .cs      (cs),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, exp_v);
        end
    endtask

    // Memory map as plain address ranges: ROM 0..3FF, RAM 400..4FF, UART 500, SR 504.
    function automatic int ref_region(input logic [31:0] a);
        if (a < 32'h400)  return 0;
        if (a < 32'h500)  return 1;
        if (a == 32'h500) return 2;
        if (a == 32'h504) return 3;
        return -1;
    endfunction

    // Called right after a clock edge; predicts the edge that will accept the request.
    task automatic launch(input logic [31:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        int   r;
        int   p;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        p = (cyc + 1 > next_ok) ? cyc + 1 : next_ok;
        r = ref_region(a);
        e.addr  = a;
        e.wdata = d;
        e.we    = w;
        if (r < 0) begin
            e.cs        = 4'd0;
            e.cs_cycles = 0;
            e.cs_start  = 0;
            e.rdy_cyc   = p;
            e.rdata     = 32'd0;
            e.err       = ERR_EXP;
            next_ok     = p + 2;
        end else begin
            e.cs        = 4'(1 << r);
            e.cs_cycles = WS_REF[r] + 1;
            e.cs_start  = p;
            e.rdy_cyc   = p + WS_REF[r] + 1;
            e.rdata     = w ? 32'd0 : sd[r];
            e.err       = 1'b0;
            next_ok     = p + WS_REF[r] + 3;
        end
        q.push_back(e);
    endtask

    task automatic wait_ready();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: actual no ready required ready within 64 cycles");
            abort = 1'b1;
        end
    endtask

    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d);
        launch(a, w, d);
        wait_ready();
    endtask

    task automatic go_idle();
        req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares everything the DUT presents against the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                cs_cnt = 0;
            end else begin
                if (cs != 4'd0) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cs: actual cs %b required no access", cs);
                    end else begin
                        chk("cs_onehot", {28'd0, cs}, {28'd0, q[0].cs});
                        chk("s_we", {31'd0, s_we}, {31'd0, q[0].we});
                        chk("s_addr", s_addr, q[0].addr);
                        if (q[0].we) chk("s_wdata", s_wdata, q[0].wdata);
                        if (cs_cnt == 0) chk("cs_start_cycle", cyc, q[0].cs_start);
                        cs_cnt++;
                    end
                end else begin
                    chk("s_we_without_cs", {31'd0, s_we}, 32'd0);
                end
                if (ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: actual ready=1 required no pending access");
                    end else begin
                        e = q.pop_front();
                        chk("rdata", rdata, e.rdata);
                        chk("err", {31'd0, err}, {31'd0, e.err});
                        chk("ready_cycle", cyc, e.rdy_cyc);
                        chk("cs_cycles", cs_cnt, e.cs_cycles);
                        chk("cs_at_ready", {28'd0, cs}, 32'd0);
                    end
                    cs_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual simulation still running required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          ready_seen;
        for (int i = 0; i < 4; i++) sd[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", {28'd0, cs}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_s_we", {31'd0, s_we}, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        reset = 1'b0;
        next_ok = cyc + 1;

        // Directed: ROM read, RAM write, UART with wait states, unmapped.
        for (int i = 0; i < 4; i++) sd[i] = $urandom;
        sd[0] = 32'hDEAD_BEEF;
        access(32'h0000_03FC, 1'b0, 32'd0);
        go_idle();
        access(32'h0000_0410, 1'b1, 32'h1234_5678);
        go_idle();
        sd[2] = 32'hCAFE_0500;
        access(32'h0000_0500, 1'b0, 32'd0);
        go_idle();
        access(32'h0000_0600, 1'b0, 32'hFFFF_FFFF);
        go_idle();

        // Reset during the UART wait states: everything clears and no ready follows.
        launch(32'h0000_0500, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_cs", {28'd0, cs}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_s_we", {31'd0, s_we}, 32'd0);
        chk("abort_s_addr", s_addr, 32'd0);
        q.delete();
        reset = 1'b0;
        next_ok = cyc + 1;
        ready_seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ready) ready_seen++;
        end
        chk("abort_no_ready", ready_seen, 0);

        // Back-to-back with req held: SR then RAM.
        sd[3] = 32'h5151_5151;
        sd[1] = 32'h4040_4040;
        access(32'h0000_0504, 1'b0, 32'd0);
        access(32'h0000_0400, 1'b0, 32'd0);
        go_idle();

        for (int t = 0; t < 150 && !abort; t++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'($urandom_range(0, 'h3FF));
                1:       a = 32'h400 + 32'($urandom_range(0, 'hFF));
                2:       a = 32'h500;
                3:       a = 32'h504;
                4:       a = 32'($urandom_range('h501, 'h7FF));
                default: a = $urandom;
            endcase
            for (int i = 0; i < 4; i++) sd[i] = $urandom;
            access(a, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                req = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_decoder_ws.md
# bus_decoder_ws

Parametrised, registered memory-map decoder with per-region wait states, sitting between the CPU data port and the ROM, RAM, UART and status-register slaves. It replaces the purely combinational chip-select decode with a small access FSM that latches the request and drives one-hot chip selects. It counts a per-region number of wait states, captures read data from the selected slave and returns a single-cycle `ready`, with optional error signalling for unmapped addresses.

## Interface
- `N_SLAVES`, 4: number of decoded regions.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `WS_W`, 4: wait-state counter width.
- `BASE`, {0x504,0x500,0x400,0x000}: packed `N_SLAVES*ADDR_W` region bases; slave i occupies slice i.
- `MASK`, {0xFFFFFFFF,0xFFFFFFFF,0xFFFFFF00,0xFFFFFC00}: packed per-region address masks.
- `WAIT`, {0,2,0,0}: packed `N_SLAVES*WS_W` wait states per region.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: CPU access request; held with `addr`/`we`/`wdata` stable until `ready`.
- `we` in 1: 1 = write, 0 = read.
- `addr` in ADDR_W: byte address.
- `wdata` in DATA_W: write data.
- `rdata` out DATA_W: read data, valid while `ready`=1.
- `ready` out 1: one-cycle access-complete pulse.
- `err` out 1: unmapped access flag, coincident with `ready`.
- `cs` out N_SLAVES: one-hot slave chip selects.
- `s_we` out 1: slave write enable.
- `s_addr` out ADDR_W: latched address to slaves.
- `s_wdata` out DATA_W: latched write data.
- `s_rdata` in N_SLAVES*DATA_W: packed slave read data, slice i from slave i.

## Operation
- Region match rule: `(addr & MASK[i]) == BASE[i]`. On overlap the lowest index wins. No match is unmapped.
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE:** when `req`=1, latch `addr`, `we` and `wdata`. Latch the matched index into `sel` and load `cnt` = WAIT[sel]. Go to ACCESS.
  - On an unmapped access, go directly to RESP with the error flagged.
- **ACCESS:** drive `cs[sel]`=1, `s_we`=latched `we`, `s_addr` and `s_wdata`.
  - If `cnt`≠0, decrement `cnt` and stay in ACCESS.
  - If `cnt`=0, register `rdata` ← slice `sel` of `s_rdata` (0 on writes), set `ready` for the next cycle and go to RESP.
- **RESP:** `ready`=1 for exactly one cycle and all `cs` are 0. Go to IDLE.
- `req` is sampled only in IDLE. `req` arriving during ACCESS or RESP is ignored until IDLE.
- `s_we` is 0 whenever all `cs` are 0.
- Reset values: state IDLE, `cs`=0, `s_we`=0, `s_addr`=0, `s_wdata`=0, `rdata`=0, `ready`=0, `err`=0, `cnt`=0.
- Reset mid-access: at the sampling edge, all outputs return to reset values. No `ready` is issued for the aborted access.

## Timing
- Outputs `cs`, `s_*`, `rdata`, `ready` and `err` are all registered. There are no combinational paths from inputs to outputs.
- Mapped access, region with wait W:
  - `req` sampled at edge 0.
  - `cs` high for cycles 1 through W+1.
  - `ready` high in cycle W+2.
  - Back in IDLE at cycle W+3.
  - The next `req` can be sampled at edge W+3.
- Unmapped access: `req` sampled at edge 0, `ready` (and `err` if enabled) in cycle 1, IDLE in cycle 2. No `cs` is asserted.
- Minimum throughput: one access per 3 cycles (W=0).

## Configuration
- `DECODE_ERR_EN` defined: an unmapped access pulses `err`=1 together with `ready`, and `rdata` = 0.
- `DECODE_ERR_EN` undefined: `err` is tied to 0. An unmapped access still completes with `ready` and `rdata` = 0, so the CPU never hangs.

## Structure
- Package `bus_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - default `BASE`, `MASK` and `WAIT` constants for the ROM/RAM/UART/SR map;
  - `DATA_W` and `ADDR_W` defaults.
- Sub-module `region_match`: combinational. Takes `addr`, `BASE` and `MASK`; outputs `hit` and the priority-encoded `idx`. It is instantiated once.

## Test plan
- Read ROM: `addr`=0x3FC, slave0 returns 0xDEADBEEF → `cs`=0001 for 1 cycle; `ready`=1, `rdata`=0xDEADBEEF at cycle 2; `err`=0.
- Write RAM: `addr`=0x410, `wdata`=0x12345678 → `cs`=0010 and `s_we`=1 for 1 cycle; `s_wdata`=0x12345678; `ready` at cycle 2; `rdata`=0.
- UART with 2 wait states: `addr`=0x500 read → `cs`=0100 for cycles 1–3; `ready` at cycle 4.
- Unmapped: `addr`=0x600 → no `cs`; `ready` at cycle 1; `err`=1 with `DECODE_ERR_EN`, 0 without.
- Reset mid-access: `reset`=1 during the second UART wait cycle → `cs`=0, state IDLE, and no `ready` pulse ever appears.
- Back-to-back: `req` held high across two accesses (SR 0x504 then RAM 0x400) → second `cs` asserts exactly 3 cycles after the first; `ready` pulses are non-overlapping.
